// File: rtl/dpram_stream_reader.sv
// Sweeps an address window of a 1-cycle-latency RAM port and streams the words
// out on valid/ready, optionally writing CLEAR_VAL back after each read.
module dpram_stream_reader #(
    parameter int                dWidth    = 8,
    parameter int                aWidth    = 10,
    parameter logic [dWidth-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [aWidth-1:0] base,
    input  logic [aWidth:0]   len,
    input  logic              clear_en,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [aWidth-1:0] ram_addr,
    output logic              ram_we,
    output logic [dWidth-1:0] ram_d,
    input  logic [dWidth-1:0] ram_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [dWidth-1:0] out_data,
    output logic              out_last
);

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_ERASE, S_DRAIN, S_DONE
    } state_t;

    localparam logic [aWidth-1:0] A_ONE = 1;
    localparam logic [aWidth:0]   I_ONE = 1;

    state_t            state_q, state_d;
    logic [aWidth-1:0] base_q, base_d;
    logic [aWidth:0]   len_q, len_d;
    logic [aWidth:0]   idx_q, idx_d;
    logic              clear_q, clear_d;
    logic              infl_q, infl_d;
    logic              infl_last_q, infl_last_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [dWidth-1:0] dat0_q, dat0_d, dat1_q, dat1_d;
    logic              last0_q, last0_d, last1_q, last1_d;

    logic              pop;
    logic [1:0]        cnt_pop;
    logic [1:0]        fill;
    logic [aWidth:0]   idx_inc;

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = dat0_q;
    assign out_last  = last0_q;
    assign pop       = out_valid & out_ready;
    assign cnt_pop   = cnt_q - {1'b0, pop};
    assign fill      = cnt_pop + {1'b0, infl_q};
    assign idx_inc   = idx_q + I_ONE;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        idx_d       = idx_q;
        clear_d     = clear_q;
        infl_d      = 1'b0;
        infl_last_d = infl_last_q;
        dat0_d      = dat0_q;
        dat1_d      = dat1_q;
        last0_d     = last0_q;
        last1_d     = last1_q;
        cnt_d       = fill;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        ram_addr    = '0;
        ram_we      = 1'b0;
        ram_d       = CLEAR_VAL;

        // Two-entry FIFO: pop shifts the head, the returning read lands behind it.
        if (pop) begin
            dat0_d  = dat1_q;
            last0_d = last1_q;
        end
        if (infl_q) begin
            if (cnt_pop == 2'd0) begin
                dat0_d  = ram_q;
                last0_d = infl_last_q;
            end else begin
                dat1_d  = ram_q;
                last1_d = infl_last_q;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base;
                    len_d   = len;
                    clear_d = clear_en;
                    idx_d   = '0;
                    state_d = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                ram_addr = base_q + idx_q[aWidth-1:0];
                if (fill < 2'd2) begin
                    infl_d      = 1'b1;
                    infl_last_d = (idx_inc == len_q);
                    idx_d       = idx_inc;
                    if (clear_q)
                        state_d = S_ERASE;
                    else if (idx_inc == len_q)
                        state_d = S_DRAIN;
                end
            end
            S_ERASE: begin
                ram_addr = base_q + idx_q[aWidth-1:0] - A_ONE;
                ram_we   = 1'b1;
                state_d  = (idx_q == len_q) ? S_DRAIN : S_RUN;
            end
            S_DRAIN: begin
                if (cnt_q == 2'd0 && !infl_q)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // An erase already on the port still completes; only the buffer is dropped.
        if (abort && (state_q == S_RUN || state_q == S_ERASE ||
                      state_q == S_DRAIN)) begin
            state_d = S_DONE;
            infl_d  = 1'b0;
            cnt_d   = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            clear_q     <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            cnt_q       <= 2'd0;
            dat0_q      <= '0;
            dat1_q      <= '0;
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            clear_q     <= clear_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            cnt_q       <= cnt_d;
            dat0_q      <= dat0_d;
            dat1_q      <= dat1_d;
            last0_q     <= last0_d;
            last1_q     <= last1_d;
        end
    end

endmodule
